// File: rtl/ladybird_lsu.sv
// ladybird_lsu: single-outstanding load/store unit between the core and a
// word-wide data bus. Forms word-aligned requests with byte strobes, extends
// load data, and reports misaligned/illegal/timed-out accesses as errors.
module ladybird_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_we,
  input  logic [2:0]      i_funct,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [XLEN-1:0] o_data,
  output logic            o_err,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_we,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);
  // Counter is at least 8 bits, wider only when TIMEOUT needs it.
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] addr_q, data_q, rsp_data, shifted, load_ext;
  logic            we_q, rsp_err, illegal, tmo;
  logic [2:0]      funct_q;
  logic [CW-1:0]   cnt;

  // Timeout fires on the cycle whose increment would make cnt reach TIMEOUT.
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  // Outputs come only from state and latched registers.
  assign i_ready   = (state == IDLE);
  assign bus_valid = (state == REQ);
  assign o_valid   = (state == RESP);
  assign o_data    = rsp_data;
  assign o_err     = rsp_err;
  assign bus_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign bus_we    = we_q;

  // Legality of the incoming request: funct code and natural alignment.
  always_comb begin
    illegal = 1'b0;
    if (i_we) begin
      if (i_funct[2] || i_funct[1:0] == 2'b11) illegal = 1'b1;
    end else if (i_funct == 3'b011 || i_funct[2:1] == 2'b11) begin
      illegal = 1'b1;
    end
    if (i_funct[1:0] == 2'b01 && i_addr[0]) illegal = 1'b1;
    if (i_funct[1:0] == 2'b10 && i_addr[1:0] != 2'b00) illegal = 1'b1;
  end

  // Store strobes and lane-replicated write data from the latched request.
  always_comb begin
    bus_wstrb = 4'b0000;
    bus_wdata = data_q;
    case (funct_q[1:0])
      2'b00: begin
        bus_wstrb = 4'b0001 << addr_q[1:0];
        bus_wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        bus_wstrb = 4'b0011 << addr_q[1:0];
        bus_wdata = {2{data_q[15:0]}};
      end
      2'b10:   bus_wstrb = 4'b1111;
      default: bus_wstrb = 4'b0000;
    endcase
    if (!we_q) bus_wstrb = 4'b0000;
  end

  // Load extraction: shift the addressed lane down, then sign/zero-extend.
  always_comb begin
    shifted  = bus_rdata >> {addr_q[1:0], 3'b000};
    load_ext = '0;
    case (funct_q)
      3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = bus_rdata;
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state; timeout wins over a same-cycle bus event.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_valid) state_nx = illegal ? RESP : REQ;
      REQ: begin
        if (tmo)            state_nx = RESP;
        else if (bus_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (tmo || bus_rvalid) state_nx = RESP;
      end
      RESP: if (o_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      funct_q  <= 3'b000;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          addr_q   <= i_addr;
          data_q   <= i_data;
          we_q     <= i_we;
          funct_q  <= i_funct;
          cnt      <= '0;
          rsp_data <= '0;
          rsp_err  <= illegal;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else if (bus_rvalid) begin
            rsp_data <= we_q ? '0 : load_ext;
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ladybird_lsu.sv
// Scoreboard bench for ladybird_lsu: stimulus pushes expected bus requests and
// responses; a bus model and a response monitor check them independently.
module tb_ladybird_lsu;
  localparam int TO = 8;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        i_valid = 1'b0, i_ready, i_we = 1'b0;
  logic [31:0] i_addr = '0, i_data = '0;
  logic [2:0]  i_funct = '0;
  logic        o_valid, o_ready, o_err;
  logic [31:0] o_data;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  ladybird_lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_data(i_data),
    .i_we(i_we), .i_funct(i_funct),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_err(o_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  strb;
    logic        we;
    int          rdly, rvdly, t;
  } bus_t;
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          t, lat, hold;
  } rsp_t;

  bus_t bq[$];
  rsp_t rq[$];
  int   checks = 0, passed = 0;
  int   bus_mode = 0;   // 0 normal, 1 never responds, 2 accepts but never returns data
  int   next_hold = 0;
  logic late_req = 1'b0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---- reference model, from the access rules ----
  function automatic int size_of(logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit is_illegal(logic we, logic [2:0] f, logic [31:0] a);
    if (we && f > 3'd2) return 1'b1;
    if (!we && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
    return (int'(a[1:0]) % size_of(f)) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(logic [2:0] f, logic [31:0] a);
    logic [3:0] s;
    int b;
    s = '0;
    b = int'(a[1:0]);
    for (int i = 0; i < 4; i++) if (i >= b && i < b + size_of(f)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f, logic [31:0] d);
    logic [31:0] w;
    int n;
    n = size_of(f);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f, logic [31:0] a, logic [31:0] r);
    longint v;
    int n, b;
    n = size_of(f);
    b = int'(a[1:0]);
    if (n == 4) return r;
    v = longint'(r >> (8*b)) & ((64'd1 << (8*n)) - 1);
    if (!f[2] && v[8*n-1]) v = v - (64'sd1 <<< (8*n));
    return v[31:0];
  endfunction

  // Issue one request; expectations are pushed when track is set.
  task automatic issue(logic we, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                       logic [31:0] rd, int rdly, int rvdly, bit track);
    bus_t be;
    rsp_t re;
    bit   ill;
    int   w;
    w = 0;
    @(negedge clk);
    while (!i_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("i_ready_wait", i_ready, 1'b1);
    i_valid = 1'b1; i_we = we; i_funct = f; i_addr = a; i_data = d;
    ill = is_illegal(we, f, a);
    if (track) begin
      re.t    = cyc;
      re.err  = ill || (bus_mode == 1);
      re.data = (ill || we || bus_mode == 1) ? 32'h0 : exp_load(f, a, rd);
      re.lat  = ill ? 1 : (bus_mode == 1 ? 1 + TO : 3 + rdly + rvdly);
      re.hold = next_hold;
      rq.push_back(re);
      if (!ill && bus_mode == 0) begin
        be.addr = {a[31:2], 2'b00};
        be.we = we;
        be.strb = we ? exp_strb(f, a) : 4'b0000;
        be.wdata = exp_wdata(f, d);
        be.rdata = rd; be.rdly = rdly; be.rvdly = rvdly; be.t = cyc;
        bq.push_back(be);
      end
    end
    @(negedge clk);
    i_valid = 1'b0; i_addr = $urandom; i_data = $urandom;
    i_funct = 3'($urandom); i_we = 1'($urandom);
    chk("i_ready_drop", i_ready, 1'b0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((rq.size() != 0 || bq.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_rsp", rq.size(), 0);
    chk("drain_bus", bq.size(), 0);
  endtask

  // Bus model: checks each request and answers with the queued delays/data.
  initial begin : bus_model
    bus_t e;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ready = 1'b0; bus_rvalid = late_req; bus_rdata = $urandom;
      if (bus_valid && nrst) begin
        if (bus_mode == 2) bus_ready = 1'b1;
        else if (bus_mode == 0) begin
          if (bq.size() == 0) chk("bus_spurious", bus_valid, 1'b0);
          else begin
            e = bq.pop_front();
            chk("bus_start", cyc, e.t + 1);
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_we", bus_we, e.we);
            chk("bus_wstrb", bus_wstrb, e.strb);
            if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
            for (int k = 0; k < e.rdly; k++) begin
              bus_ready = 1'b0;
              @(negedge clk);
              chk("bus_hold_valid", bus_valid, 1'b1);
              chk("bus_hold_addr", bus_addr, e.addr);
              chk("bus_hold_wstrb", bus_wstrb, e.strb);
            end
            bus_ready = 1'b1;
            @(negedge clk);
            bus_ready = 1'b0;
            chk("bus_drop", bus_valid, 1'b0);
            for (int k = 0; k < e.rvdly; k++) @(negedge clk);
            bus_rvalid = 1'b1; bus_rdata = e.rdata;
            @(negedge clk);
            bus_rvalid = 1'b0; bus_rdata = $urandom;
          end
        end
      end
    end
  end

  // Response monitor: compares every presented response, random backpressure.
  initial begin : monitor
    rsp_t e;
    bit first, popped;
    int hold;
    first = 1'b1; popped = 1'b0; hold = 0;
    o_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (popped) begin
        chk("rsp_drop", o_valid, 1'b0);
        popped = 1'b0;
      end
      if (!nrst) o_ready = 1'b0;
      else if (o_valid) begin
        if (rq.size() == 0) begin
          chk("rsp_spurious", o_valid, 1'b0);
          o_ready = 1'b1;
        end else begin
          e = rq[0];
          if (first) begin
            chk("rsp_latency", cyc, e.t + e.lat);
            hold = e.hold;
            first = 1'b0;
          end
          chk("rsp_data", o_data, e.data);
          chk("rsp_err", o_err, e.err);
          if (hold > 0) begin
            o_ready = 1'b0;
            hold--;
          end else if (e.hold > 0) o_ready = 1'b1;
          else o_ready = ($urandom_range(0, 3) != 0);
          if (o_ready) begin
            void'(rq.pop_front());
            first = 1'b1;
            popped = 1'b1;
          end
        end
      end else o_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : stim
    logic        we;
    logic [2:0]  f;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, 32'h0);
    chk("rst_bus_wstrb", bus_wstrb, 4'h0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_i_ready", i_ready, 1'b1);

    // directed cases
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b1);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b1);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 1'b1);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 0, 1, 1'b1);
    issue(1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1'b1);
    issue(1'b1, 3'b001, 32'h103, 32'hABCD, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1);
    drain();
    next_hold = 4;
    issue(1'b0, 3'b101, 32'h1F2, 32'h0, 32'h1234_8765, 3, 2, 1'b1);
    next_hold = 0;
    drain();

    // timeout with a silent bus, then a late rvalid that must be ignored
    bus_mode = 1;
    issue(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 0, 1'b1);
    drain();
    chk("tmo_bus_idle", bus_valid, 1'b0);
    late_req = 1'b1;
    repeat (2) @(negedge clk);
    late_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("late_ignored", o_valid, 1'b0);
    end

    // reset while waiting for read data
    bus_mode = 2;
    issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    chk("wait_busy", i_ready, 1'b0);
    nrst = 1'b0;
    @(negedge clk);
    chk("mrst_bus_valid", bus_valid, 1'b0);
    chk("mrst_o_valid", o_valid, 1'b0);
    chk("mrst_o_err", o_err, 1'b0);
    chk("mrst_o_data", o_data, 32'h0);
    chk("mrst_bus_addr", bus_addr, 32'h0);
    chk("mrst_bus_wstrb", bus_wstrb, 4'h0);
    chk("mrst_i_ready", i_ready, 1'b1);
    nrst = 1'b1;
    bus_mode = 0;
    late_req = 1'b1;
    @(negedge clk);
    late_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", o_valid, 1'b0);
    end

    // randomized traffic; total bus delay stays below the timeout
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f = 3'($urandom);
      else if (we) f = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f = 3'b000;
          1: f = 3'b001;
          2: f = 3'b010;
          3: f = 3'b100;
          default: f = 3'b101;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f)) - 32'd1);
      issue(we, f, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
